// File: rtl/config_shadow_bank_pkg.sv
// Shared types and elaboration helpers for the double-buffered configuration bank.
package config_shadow_bank_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam int BYTE_W    = 8;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANES = DEF_WIDTH / BYTE_W;

  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int lanes_f(input int w);
    return w / BYTE_W;
  endfunction

endpackage

// File: rtl/config_shadow_bank_if.sv
// Write/readback/commit bus between the CSR decoder (master) and the shadow bank (slave).
interface config_shadow_bank_if
  import config_shadow_bank_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 2
);

  logic                      wr_en;
  logic [AWIDTH-1:0]         wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [lanes_f(WIDTH)-1:0] wr_be;
  logic [AWIDTH-1:0]         rd_addr;
  logic [WIDTH-1:0]          rd_data;
  logic                      commit_req;
  logic                      quiesce;
  logic                      pending;
  logic                      dirty;
  logic                      commit_done;
  logic [DEPTH*WIDTH-1:0]    q_out;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr, commit_req, quiesce,
    input  rd_data, pending, dirty, commit_done, q_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr, commit_req, quiesce,
    output rd_data, pending, dirty, commit_done, q_out
  );

endinterface

// File: rtl/config_shadow_bank_entry.sv
// One shadow/active register pair: byte-enable writes hit the shadow, copy strobe loads active.
module config_shadow_entry
  import config_shadow_bank_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr,
  input  logic [lanes_f(WIDTH)-1:0] i_be,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_copy,
  output logic [WIDTH-1:0]          o_shadow,
  output logic [WIDTH-1:0]          o_active
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;

  // Copy and write share an edge: active takes the pre-write shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= INIT_VAL;
      r_active <= INIT_VAL;
    end else begin
      if (i_copy) r_active <= r_shadow;
      if (i_wr) begin
        for (int k = 0; k < lanes_f(WIDTH); k++) begin
          if (i_be[k]) r_shadow[k*BYTE_W +: BYTE_W] <= i_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign o_shadow = r_shadow;
  assign o_active = r_active;

endmodule

// File: rtl/config_shadow_bank.sv
// Double-buffered config bank; commit copies every shadow into active once the consumer is quiescent.
//   state  | meaning
//   S_IDLE | no commit outstanding
//   S_WAIT | commit requested, waiting for quiesce
module config_shadow_bank
  import config_shadow_bank_pkg::*;
#(
  parameter int                     WIDTH  = 32,
  parameter int                     DEPTH  = 4,
  parameter int                     AWIDTH = 2,
  parameter logic [DEPTH*WIDTH-1:0] INIT   = '0
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  config_shadow_bank_if.slave bus
);

  localparam int LANES = lanes_f(WIDTH);
  localparam int NSLOT = 2 ** AWIDTH;

  if (LANES * BYTE_W != WIDTH) begin : g_bad_width
    $error("config_shadow_bank: WIDTH must be a multiple of 8");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("config_shadow_bank: DEPTH must be at least 1");
  end
  if (AWIDTH < clog2_f(DEPTH)) begin : g_bad_awidth
    $error("config_shadow_bank: AWIDTH too small for DEPTH");
  end

  state_t                 r_state;
  logic                   r_pending;
  logic                   r_dirty;
  logic                   r_done;
  logic [WIDTH-1:0]       r_rd_data;

  logic [DEPTH-1:0]       w_wr_sel;
  logic [WIDTH-1:0]       w_shadow [NSLOT];
  logic [WIDTH-1:0]       w_active [DEPTH];
  logic [DEPTH*WIDTH-1:0] w_q_flat;
  logic                   w_copy;
  logic                   w_wr_hit;

  assign w_copy   = (r_state == S_WAIT) && bus.quiesce;
  assign w_wr_hit = (|w_wr_sel) && (|bus.wr_be);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign w_wr_sel[i] = bus.wr_en && (bus.wr_addr == AWIDTH'(i));

    config_shadow_entry #(
      .WIDTH   (WIDTH),
      .INIT_VAL(INIT[i*WIDTH +: WIDTH])
    ) u_entry (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (w_wr_sel[i]),
      .i_be    (bus.wr_be),
      .i_data  (bus.wr_data),
      .i_copy  (w_copy),
      .o_shadow(w_shadow[i]),
      .o_active(w_active[i])
    );

    assign w_q_flat[i*WIDTH +: WIDTH] = w_active[i];
  end

  // Unpopulated address slots read back as zero.
  for (genvar j = DEPTH; j < NSLOT; j++) begin : g_pad
    assign w_shadow[j] = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_dirty   <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_shadow[bus.rd_addr];
      r_done    <= w_copy;
      if (w_wr_hit)    r_dirty <= 1'b1;
      else if (w_copy) r_dirty <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.commit_req) begin
            r_state   <= S_WAIT;
            r_pending <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.quiesce) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.pending     = r_pending;
  assign bus.dirty       = r_dirty;
  assign bus.commit_done = r_done;
  assign bus.q_out       = w_q_flat;

endmodule

// File: tb/tb_config_shadow_bank.sv
// Bench for config_shadow_bank: directed table, corner sequences and random traffic vs a reference model.
module tb_config_shadow_bank;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int A  = 2;
  localparam int D3 = 3;
  localparam logic [D*W-1:0]  INIT4 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
  localparam logic [D3*W-1:0] INIT3 = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_shadow_bank_if #(.WIDTH(W), .DEPTH(D),  .AWIDTH(A)) bus4 ();
  config_shadow_bank_if #(.WIDTH(W), .DEPTH(D3), .AWIDTH(A)) bus3 ();

  config_shadow_bank #(.WIDTH(W), .DEPTH(D), .AWIDTH(A), .INIT(INIT4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus4)
  );
  config_shadow_bank #(.WIDTH(W), .DEPTH(D3), .AWIDTH(A), .INIT(INIT3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the depth-4 bank
  logic [W-1:0] m_sh [D];
  logic [W-1:0] m_act[D];
  logic [W-1:0] m_rd;
  logic         m_dirty, m_wait, m_done;

  typedef struct {
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  rd_addr;
    logic        req;
    logic        qui;
    logic [31:0] e_rd;
    logic        e_pend;
    logic        e_dirty;
    logic        e_done;
    logic [31:0] e_q2;
  } vec_t;

  vec_t vt[7];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [D*W-1:0] m_qflat();
    logic [D*W-1:0] r;
    for (int i = 0; i < D; i++) r[i*W +: W] = m_act[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_sh[i]  = INIT4[i*W +: W];
      m_act[i] = INIT4[i*W +: W];
    end
    m_rd = '0;
    m_dirty = 1'b0;
    m_wait = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    bit hit, copy;
    int a;
    a    = int'(bus4.wr_addr);
    hit  = bus4.wr_en && (a < D) && (bus4.wr_be != 4'b0);
    copy = m_wait && bus4.quiesce;
    m_rd = (int'(bus4.rd_addr) < D) ? m_sh[bus4.rd_addr] : '0;
    if (copy) for (int i = 0; i < D; i++) m_act[i] = m_sh[i];
    m_done = copy;
    m_wait = m_wait ? !bus4.quiesce : bus4.commit_req;
    if (hit) m_dirty = 1'b1;
    else if (copy) m_dirty = 1'b0;
    if (hit) m_sh[a] = merge(m_sh[a], bus4.wr_data, bus4.wr_be);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " rd_data"},     bus4.rd_data,     m_rd);
    chk({tag, " pending"},     bus4.pending,     m_wait);
    chk({tag, " dirty"},       bus4.dirty,       m_dirty);
    chk({tag, " commit_done"}, bus4.commit_done, m_done);
    chk({tag, " q_out"},       bus4.q_out,       m_qflat());
  endtask

  task automatic drive(input logic we, input logic [1:0] ad, input logic [31:0] dt,
                       input logic [3:0] be, input logic [1:0] ra, input logic rq,
                       input logic qu);
    bus4.wr_en = we;  bus4.wr_addr = ad; bus4.wr_data = dt; bus4.wr_be = be;
    bus4.rd_addr = ra; bus4.commit_req = rq; bus4.quiesce = qu;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    int dones;
    logic [127:0] q_hold;

    vt[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0101, 2'd2, 1'b0, 1'b1,
              32'h1000_0002, 1'b0, 1'b1, 1'b0, 32'h1000_0002};
    vt[1] = '{1'b0, 2'd0, 32'h0, 4'b0000, 2'd2, 1'b1, 1'b1,
              32'h10AD_00EF, 1'b1, 1'b1, 1'b0, 32'h1000_0002};
    vt[2] = '{1'b0, 2'd0, 32'h0, 4'b0000, 2'd2, 1'b0, 1'b1,
              32'h10AD_00EF, 1'b0, 1'b0, 1'b1, 32'h10AD_00EF};
    vt[3] = '{1'b0, 2'd0, 32'h0, 4'b0000, 2'd2, 1'b0, 1'b1,
              32'h10AD_00EF, 1'b0, 1'b0, 1'b0, 32'h10AD_00EF};
    vt[4] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 4'b0000, 2'd2, 1'b0, 1'b1,
              32'h10AD_00EF, 1'b0, 1'b0, 1'b0, 32'h10AD_00EF};
    vt[5] = '{1'b1, 2'd2, 32'h5500_0000, 4'b1000, 2'd2, 1'b0, 1'b0,
              32'h10AD_00EF, 1'b0, 1'b1, 1'b0, 32'h10AD_00EF};
    vt[6] = '{1'b0, 2'd0, 32'h0, 4'b0000, 2'd2, 1'b0, 1'b0,
              32'h55AD_00EF, 1'b0, 1'b1, 1'b0, 32'h10AD_00EF};

    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    bus3.wr_en = 1'b0; bus3.wr_addr = '0; bus3.wr_data = '0; bus3.wr_be = '0;
    bus3.rd_addr = '0; bus3.commit_req = 1'b0; bus3.quiesce = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", bus4.rd_data, 32'h0);
    chk("reset pending", bus4.pending, 1'b0);
    chk("reset dirty", bus4.dirty, 1'b0);
    chk("reset commit_done", bus4.commit_done, 1'b0);
    chk("reset q_out", bus4.q_out, INIT4);
    rst_n = 1'b1;
    model_reset();
    tick("idle");

    // Directed table
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].wr_en, vt[i].addr, vt[i].data, vt[i].be, vt[i].rd_addr, vt[i].req, vt[i].qui);
      tick("table");
      chk($sformatf("vec%0d rd_data", i), bus4.rd_data, vt[i].e_rd);
      chk($sformatf("vec%0d pending", i), bus4.pending, vt[i].e_pend);
      chk($sformatf("vec%0d dirty", i), bus4.dirty, vt[i].e_dirty);
      chk($sformatf("vec%0d commit_done", i), bus4.commit_done, vt[i].e_done);
      chk($sformatf("vec%0d q2", i), bus4.q_out[64 +: 32], vt[i].e_q2);
    end

    // Long wait with quiesce low, extra requests merged
    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd2, 1'b1, 1'b0);
    tick("wait_req");
    q_hold = bus4.q_out;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd2, (c % 3) == 0, 1'b0);
      tick("wait_hold");
      chk("wait pending", bus4.pending, 1'b1);
      chk("wait q_stable", bus4.q_out, q_hold);
    end
    dones = 0;
    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd2, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick("wait_release");
      if (bus4.commit_done) dones++;
    end
    chk("wait one_done", dones, 1);
    chk("wait q2_new", bus4.q_out[64 +: 32], 32'h55AD_00EF);

    // Write on the copy edge
    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd0, 1'b1, 1'b0);
    tick("cedge_req");
    drive(1'b1, 2'd0, 32'hCAFE_F00D, 4'hF, 2'd0, 1'b0, 1'b1);
    tick("cedge_copy");
    chk("cedge done", bus4.commit_done, 1'b1);
    chk("cedge active0_old", bus4.q_out[31:0], 32'h1000_0000);
    chk("cedge dirty", bus4.dirty, 1'b1);
    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    tick("cedge_after");
    chk("cedge shadow0_new", bus4.rd_data, 32'hCAFE_F00D);
    chk("cedge dirty_after", bus4.dirty, 1'b1);

    // Async reset mid-cycle while in WAIT
    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd0, 1'b1, 1'b0);
    tick("rst_req");
    chk("rst pending_before", bus4.pending, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async rd_data", bus4.rd_data, 32'h0);
    chk("async pending", bus4.pending, 1'b0);
    chk("async dirty", bus4.dirty, 1'b0);
    chk("async commit_done", bus4.commit_done, 1'b0);
    chk("async q_out", bus4.q_out, INIT4);
    model_reset();
    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      tick("post_rst");
      if (bus4.commit_done) dones++;
    end
    chk("post_rst no_done", dones, 0);
    chk("post_rst q_init", bus4.q_out, INIT4);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1), 2'($urandom), $urandom, 4'($urandom), 2'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      tick("rand");
    end
    drive(1'b0, 2'd0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0);

    // Depth-3 bank: out-of-range address
    bus3.wr_en = 1'b1; bus3.wr_addr = 2'd3; bus3.wr_data = 32'hFFFF_FFFF; bus3.wr_be = 4'hF;
    bus3.rd_addr = 2'd3;
    tick("d3_oob");
    chk("d3 oob dirty", bus3.dirty, 1'b0);
    chk("d3 oob q", bus3.q_out, INIT3);
    bus3.wr_en = 1'b0; bus3.rd_addr = 2'd3;
    tick("d3_rd3");
    chk("d3 rd3_zero", bus3.rd_data, 32'h0);
    bus3.rd_addr = 2'd2;
    tick("d3_rd2");
    chk("d3 rd2_init", bus3.rd_data, 32'h3000_0002);
    bus3.wr_en = 1'b1; bus3.wr_addr = 2'd2; bus3.wr_data = 32'h1234_5678; bus3.wr_be = 4'hF;
    tick("d3_wr2");
    bus3.wr_en = 1'b0;
    tick("d3_rd2b");
    chk("d3 rd2_new", bus3.rd_data, 32'h1234_5678);
    chk("d3 dirty", bus3.dirty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
